light_monitor: RTL
==================

Name: light_monitor

Overview:
- Receive-side observer for the three traffic-light lines J, P and C produced by the light controller.
- Samples the lights every clock and decodes the current phase.
- Publishes a remaining-time countdown for display.
- Raises sticky fault flags on illegal light codes, out-of-order phases, or wrong phase durations; used by the display and supervisory logic.

Parameters:
- T_J, 14, nominal J phase duration in clk cycles
- T_P, 8, nominal P phase duration in clk cycles
- T_C, 17, nominal C phase duration in clk cycles
- TOL, 0, allowed deviation from nominal duration, in cycles
- CW, 12, dwell counter / countdown width

Ports:
- clk  input  1  system clock, 1 s period; all logic on posedge
- rst  input  1  asynchronous, active-high reset
- J  input  1  J light, high = pass
- P  input  1  P light, high = pass
- C  input  1  C light, high = pass
- clr_fault  input  1  synchronous clear of all sticky fault flags
- phase  output  2  0 = none/unknown, 1 = J, 2 = P, 3 = C
- remaining  output  CW  cycles left in current phase; 0 when phase = 0
- phase_change  output  1  one-cycle pulse when phase takes a new valid value
- fault_onehot  output  1  sticky: light code not exactly one-hot
- fault_seq  output  1  sticky: transition not J->P->C->J
- fault_time  output  1  sticky: phase duration outside T_x ± TOL
- fault  output  1  OR of the three sticky flags, registered

Behaviour:
- Reset (async, rst = 1):
  - All outputs 0.
  - State = IDLE, dwell counter dw = 0, previous code prev = 000.
- Sampling and latency:
  - {J,P,C} sampled at each posedge; all outputs registered.
  - A light change visible before edge n is reflected on outputs after edge n (1 clock latency).
- Code classification: exactly one bit high = valid phase X; otherwise illegal.
- States:
  - IDLE: no phase known.
  - ACQ: first phase after IDLE; it may be partial, so its duration is not checked.
  - TRACK: all checks active.
- IDLE:
  - Valid code X -> phase = X, dw = 1, remaining = T_X-1, phase_change = 1, go to ACQ.
  - Illegal code -> stay in IDLE; fault_onehot = 1 unless the code is 000 immediately after reset or clr.
  - Decided exception: 000 in IDLE is not a fault. Every other illegal code is a fault in every state.
- ACQ / TRACK, same valid code as prev: dw = dw+1, saturating at 2^CW-1.
- ACQ / TRACK, new valid code Y:
  - If Y != next(X): fault_seq = 1.
  - In TRACK only: if |dw - T_X| > TOL, fault_time = 1. dw here equals the cycles X was observed.
  - Then phase = Y, dw = 1, remaining = T_Y-1, phase_change = 1, go to TRACK (also from ACQ).
  - Tracking continues after any fault.
- Overrun, TRACK only: at the edge where the same code is held and dw+1 > T_X+TOL, set fault_time immediately. The flag is not set again at the later transition; it is already sticky.
- ACQ / TRACK, illegal code: fault_onehot = 1, phase = 0, remaining = 0, dw = 0, go to IDLE (re-acquire).
- remaining = T_X - dw, saturating at 0; never wraps.
- phase_change:
  - Exactly one cycle high per new valid phase.
  - 0 when the phase is unchanged or becomes 0.
- clr_fault: clears all sticky flags on the next edge. If a fault event occurs on that same edge, set wins.
- fault: updated on the same edge as the flags.
- rst mid-phase: everything returns to reset values immediately. The next valid phase enters ACQ and is not duration-checked.

Test Plan:
1. Nominal: after reset drive J 14, P 8, C 17 cycles, repeated twice.
   - phase goes 1, 2, 3, 1, 2, 3.
   - remaining counts 13 down to 0 for J, 7 to 0 for P, 16 to 0 for C.
   - One phase_change pulse per entry; all fault flags 0.
2. Short phase: in TRACK drive P for only 7 cycles.
   - fault_time = 1 and fault = 1 after the P->C edge.
   - Flags stay 1 through later nominal phases until a clr_fault pulse clears both.
3. Overrun: in TRACK hold C for 20 cycles.
   - fault_time rises after the 18th C sample.
   - remaining holds 0; phase stays 3; no second event at the C->J transition.
4. Order violation: J (14 cycles) then C.
   - fault_seq = 1; phase = 3; phase_change pulses; fault_time stays 0.
5. Illegal code: J and P both high for 1 cycle mid-J.
   - fault_onehot = 1, phase = 0, remaining = 0, state IDLE.
   - Next P lasting 3 cycles enters ACQ with no fault_time; the following C at 17 cycles raises no new fault.
6. Reset and clear races:
   - Assert rst asynchronously mid-C: all outputs 0 before the next edge.
   - Assert clr_fault on the same edge as a J->C order violation: fault_seq stays 1.

Source files
------------

// File: rtl/light_monitor.sv
// Receive-side observer for the J/P/C traffic-light lines.
// Decodes the phase, counts down the remaining time and flags sticky faults.
module light_monitor #(
  parameter int T_J = 14,
  parameter int T_P = 8,
  parameter int T_C = 17,
  parameter int TOL = 0,
  parameter int CW  = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          J,
  input  logic          P,
  input  logic          C,
  input  logic          clr_fault,
  output logic [1:0]    phase,
  output logic [CW-1:0] remaining,
  output logic          phase_change,
  output logic          fault_onehot,
  output logic          fault_seq,
  output logic          fault_time,
  output logic          fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  localparam logic [CW-1:0] L_TJ = CW'(T_J);
  localparam logic [CW-1:0] L_TP = CW'(T_P);
  localparam logic [CW-1:0] L_TC = CW'(T_C);

  // Acceptance window per phase, one bit wider so T+TOL cannot wrap.
  localparam logic [CW:0] L_HI_J = (CW+1)'(T_J + TOL);
  localparam logic [CW:0] L_HI_P = (CW+1)'(T_P + TOL);
  localparam logic [CW:0] L_HI_C = (CW+1)'(T_C + TOL);
  localparam logic [CW:0] L_LO_J = (CW+1)'((T_J > TOL) ? T_J - TOL : 0);
  localparam logic [CW:0] L_LO_P = (CW+1)'((T_P > TOL) ? T_P - TOL : 0);
  localparam logic [CW:0] L_LO_C = (CW+1)'((T_C > TOL) ? T_C - TOL : 0);

  function automatic logic [CW-1:0] f_dur(input logic [1:0] ph);
    case (ph)
      2'd1:    f_dur = L_TJ;
      2'd2:    f_dur = L_TP;
      2'd3:    f_dur = L_TC;
      default: f_dur = '0;
    endcase
  endfunction

  function automatic logic [CW:0] f_hi(input logic [1:0] ph);
    case (ph)
      2'd1:    f_hi = L_HI_J;
      2'd2:    f_hi = L_HI_P;
      2'd3:    f_hi = L_HI_C;
      default: f_hi = '0;
    endcase
  endfunction

  function automatic logic [CW:0] f_lo(input logic [1:0] ph);
    case (ph)
      2'd1:    f_lo = L_LO_J;
      2'd2:    f_lo = L_LO_P;
      2'd3:    f_lo = L_LO_C;
      default: f_lo = '0;
    endcase
  endfunction

  function automatic logic [1:0] f_next(input logic [1:0] ph);
    case (ph)
      2'd1:    f_next = 2'd2;
      2'd2:    f_next = 2'd3;
      2'd3:    f_next = 2'd1;
      default: f_next = 2'd0;
    endcase
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_dw;
  logic [2:0]    r_prev;

  logic [2:0]    w_code;
  logic [1:0]    w_ph;
  logic          w_valid;
  logic          w_live;
  logic          w_same;
  logic          w_new;
  logic          w_sat;
  logic [CW-1:0] w_dw_inc;
  logic [CW-1:0] w_t_cur;
  logic [CW-1:0] w_rem_same;
  logic [CW-1:0] w_t_new;
  logic          w_ev_oh;
  logic          w_ev_seq;
  logic          w_ev_time;
  logic          w_nx_oh;
  logic          w_nx_seq;
  logic          w_nx_time;

  assign w_code = {J, P, C};

  always_comb begin
    w_ph = 2'd0;
    unique case (1'b1)
      (w_code == 3'b100): w_ph = 2'd1;
      (w_code == 3'b010): w_ph = 2'd2;
      (w_code == 3'b001): w_ph = 2'd3;
      default:            w_ph = 2'd0;
    endcase
  end

  assign w_valid    = (w_ph != 2'd0);
  assign w_live     = (r_state != S_IDLE);
  assign w_same     = w_live && w_valid && (w_code == r_prev);
  assign w_new      = w_live && w_valid && (w_code != r_prev);
  assign w_sat      = &r_dw;
  assign w_dw_inc   = w_sat ? r_dw : r_dw + 1'b1;
  assign w_t_cur    = f_dur(phase);
  assign w_t_new    = f_dur(w_ph);
  assign w_rem_same = (w_dw_inc >= w_t_cur) ? '0 : w_t_cur - w_dw_inc;

  // 000 while idle is the quiet bus after reset, not a fault.
  assign w_ev_oh  = !w_valid && (w_live || (w_code != 3'b000));
  assign w_ev_seq = w_new && (w_ph != f_next(phase));

  // Overrun fires once at the crossing; the later transition then
  // only has to catch phases that ended too early.
  assign w_ev_time = (r_state == S_TRACK) &&
                     ((w_new && ({1'b0, r_dw} < f_lo(phase))) ||
                      (w_same && !w_sat &&
                       ({1'b0, r_dw} == f_hi(phase))));

  assign w_nx_oh   = (fault_onehot & ~clr_fault) | w_ev_oh;
  assign w_nx_seq  = (fault_seq    & ~clr_fault) | w_ev_seq;
  assign w_nx_time = (fault_time   & ~clr_fault) | w_ev_time;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_dw         <= '0;
      r_prev       <= 3'b000;
      phase        <= 2'd0;
      remaining    <= '0;
      phase_change <= 1'b0;
      fault_onehot <= 1'b0;
      fault_seq    <= 1'b0;
      fault_time   <= 1'b0;
      fault        <= 1'b0;
    end else begin
      r_prev       <= w_code;
      phase_change <= 1'b0;
      fault_onehot <= w_nx_oh;
      fault_seq    <= w_nx_seq;
      fault_time   <= w_nx_time;
      fault        <= w_nx_oh | w_nx_seq | w_nx_time;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            phase        <= w_ph;
            r_dw         <= CW'(1);
            remaining    <= w_t_new - 1'b1;
            phase_change <= 1'b1;
            r_state      <= S_ACQ;
          end else begin
            phase     <= 2'd0;
            remaining <= '0;
            r_dw      <= '0;
          end
        end
        S_ACQ, S_TRACK: begin
          if (!w_valid) begin
            phase     <= 2'd0;
            remaining <= '0;
            r_dw      <= '0;
            r_state   <= S_IDLE;
          end else if (w_same) begin
            r_dw      <= w_dw_inc;
            remaining <= w_rem_same;
          end else begin
            phase        <= w_ph;
            r_dw         <= CW'(1);
            remaining    <= w_t_new - 1'b1;
            phase_change <= 1'b1;
            r_state      <= S_TRACK;
          end
        end
        default: begin
          phase     <= 2'd0;
          remaining <= '0;
          r_dw      <= '0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
